// File: rtl/fp_norm_stage.sv
// fp_norm_stage: two-stage mantissa normalizer.
//   S1 registers the operand and its leading-zero count.
//   S2 shifts the mantissa left and lowers the exponent by the same amount.
// Both stages share one advance enable (global stall) driven by the output handshake.
// Optional macro NORM_UFLOW_SAT_EN: when the exponent is smaller than the
// leading-zero count, shift only by the exponent, clamp it to 0 and flag O_Uflow.
module fp_norm_stage #(
    parameter int WIDTH_EXP = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Valid,
    input  logic [31:0]          I_Data,
    input  logic [WIDTH_EXP-1:0] I_Exp,
    output logic                 O_Ready,
    input  logic                 I_Ready,
    output logic                 O_Valid,
    output logic [31:0]          O_Data,
    output logic [WIDTH_EXP-1:0] O_Exp,
    output logic [4:0]           O_Shift,
    output logic                 O_Zero,
    output logic                 O_Uflow
);

    // Width wide enough to compare an exponent against a 5-bit shift count.
    localparam int CW = (WIDTH_EXP > 5) ? WIDTH_EXP : 5;

    logic                 en;
    logic [4:0]           lzc;

    logic                 s1_valid;
    logic [31:0]          s1_data;
    logic [WIDTH_EXP-1:0] s1_exp;
    logic [4:0]           s1_lzc;
    logic                 s1_zero;

    logic [31:0]          nxt_data;
    logic [WIDTH_EXP-1:0] nxt_exp;
    logic [4:0]           nxt_shift;
    logic                 nxt_uflow;

    // The whole pipeline moves whenever the output slot is empty or being drained.
    assign en      = !O_Valid | I_Ready;
    assign O_Ready = en;

    // Leading-zero count: the highest set bit wins; a zero mantissa yields 0.
    always_comb begin
        lzc = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (I_Data[i]) begin
                lzc = 5'(31 - i);
            end
        end
    end

    // Stage 1: capture operand, its zero count and zero flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_exp   <= '0;
            s1_lzc   <= '0;
            s1_zero  <= 1'b0;
        end else if (en) begin
            s1_valid <= I_Valid;
            s1_data  <= I_Data;
            s1_exp   <= I_Exp;
            s1_lzc   <= lzc;
            s1_zero  <= (I_Data == 32'd0);
        end
    end

    // Stage 2 datapath: normalize, adjust exponent, optionally saturate on underflow.
    always_comb begin
        nxt_data  = s1_data << s1_lzc;
        // Subtraction wraps modulo 2^WIDTH_EXP; truncating the count first gives the same residue.
        nxt_exp   = s1_exp - WIDTH_EXP'(s1_lzc);
        nxt_shift = s1_lzc;
        nxt_uflow = 1'b0;
`ifdef NORM_UFLOW_SAT_EN
        if (!s1_zero && (CW'(s1_exp) < CW'(s1_lzc))) begin
            // exp < lzc <= 31, so the exponent itself fits the 5-bit shift field.
            nxt_data  = s1_data << s1_exp;
            nxt_exp   = '0;
            nxt_shift = 5'(s1_exp);
            nxt_uflow = 1'b1;
        end
`endif
        if (s1_zero) begin
            nxt_data  = '0;
            nxt_exp   = '0;
            nxt_shift = '0;
            nxt_uflow = 1'b0;
        end
    end

    // Stage 2: result registers, which are the module outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            O_Valid <= 1'b0;
            O_Data  <= '0;
            O_Exp   <= '0;
            O_Shift <= '0;
            O_Zero  <= 1'b0;
        end else if (en) begin
            O_Valid <= s1_valid;
            O_Data  <= nxt_data;
            O_Exp   <= nxt_exp;
            O_Shift <= nxt_shift;
            O_Zero  <= s1_zero;
        end
    end

`ifdef NORM_UFLOW_SAT_EN
    // Underflow flag travels with the stage-2 result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            O_Uflow <= 1'b0;
        end else if (en) begin
            O_Uflow <= nxt_uflow;
        end
    end
`else
    assign O_Uflow = 1'b0;
    logic unused_uflow;
    assign unused_uflow = nxt_uflow;
`endif

endmodule

// File: tb/tb_fp_norm_stage.sv
// Self-checking bench for fp_norm_stage: directed vectors, stall, reset and a
// random stream checked by a queue-based scoreboard against a behavioural model.
module tb_fp_norm_stage;

    localparam int W = 8;

    typedef struct packed {
        logic [31:0]  data;
        logic [W-1:0] exp;
        logic [4:0]   shift;
        logic         zero;
        logic         uflow;
    } res_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         I_Valid = 1'b0;
    logic [31:0]  I_Data = '0;
    logic [W-1:0] I_Exp = '0;
    logic         I_Ready = 1'b1;
    logic         O_Ready;
    logic         O_Valid;
    logic [31:0]  O_Data;
    logic [W-1:0] O_Exp;
    logic [4:0]   O_Shift;
    logic         O_Zero;
    logic         O_Uflow;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    res_t mon_exp;
    res_t mon_act;

    fp_norm_stage #(.WIDTH_EXP(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .I_Valid (I_Valid),
        .I_Data  (I_Data),
        .I_Exp   (I_Exp),
        .O_Ready (O_Ready),
        .I_Ready (I_Ready),
        .O_Valid (O_Valid),
        .O_Data  (O_Data),
        .O_Exp   (O_Exp),
        .O_Shift (O_Shift),
        .O_Zero  (O_Zero),
        .O_Uflow (O_Uflow)
    );

    always #5 clock = ~clock;

    // Reference: count zeros by walking down from bit 31, then shift and subtract.
    function automatic res_t model(input logic [31:0] d, input logic [W-1:0] e);
        res_t r;
        int   n;
        r = '0;
        if (d == 32'd0) begin
            r.zero = 1'b1;
            return r;
        end
        n = 0;
        while (d[31-n] == 1'b0) n++;
`ifdef NORM_UFLOW_SAT_EN
        if (int'(e) < n) begin
            r.data  = d << e;
            r.exp   = '0;
            r.shift = 5'(e);
            r.uflow = 1'b1;
            return r;
        end
`endif
        r.data  = d << n;
        r.exp   = W'(int'(e) - n);
        r.shift = 5'(n);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard: record accepted operands, compare every transferred result in order.
    always @(negedge clock) begin
        if (!reset) begin
            if (O_Valid && I_Ready) begin
                checks++;
                mon_act = {O_Data, O_Exp, O_Shift, O_Zero, O_Uflow};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got result data=%h exp=%0d with no outstanding operand, required none",
                             O_Data, O_Exp);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_result: got data=%h exp=%0d sh=%0d z=%b u=%b required data=%h exp=%0d sh=%0d z=%b u=%b",
                                 mon_act.data, mon_act.exp, mon_act.shift, mon_act.zero, mon_act.uflow,
                                 mon_exp.data, mon_exp.exp, mon_exp.shift, mon_exp.zero, mon_exp.uflow);
                    end
                end
            end
            if (I_Valid && O_Ready) sb.push_back(model(I_Data, I_Exp));
        end
    end

    // Present one operand and hold it until the stage accepts it.
    task automatic push_op(input logic [31:0] d, input logic [W-1:0] e);
        bit acc;
        acc = 1'b0;
        I_Valid = 1'b1;
        I_Data  = d;
        I_Exp   = e;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            acc = O_Ready;
            @(posedge clock);
            #1;
        end
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    // Single operand on an idle pipeline; checks latency and every field.
    task automatic directed(input string name, input logic [31:0] d, input logic [W-1:0] e,
                            input logic [31:0] xd, input logic [W-1:0] xe, input logic [4:0] xs,
                            input logic xz, input logic xu);
        int lat;
        bit seen;
        @(posedge clock); #1;
        I_Ready = 1'b1;
        I_Valid = 1'b1;
        I_Data  = d;
        I_Exp   = e;
        @(posedge clock); #1;
        I_Valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            lat++;
            if (O_Valid) seen = 1'b1;
        end
        chk({name, "_latency"}, 64'(seen ? lat : 0), 64'd2);
        chk({name, "_data"},  64'(O_Data),  64'(xd));
        chk({name, "_exp"},   64'(O_Exp),   64'(xe));
        chk({name, "_shift"}, 64'(O_Shift), 64'(xs));
        chk({name, "_zero"},  64'(O_Zero),  64'(xz));
        chk({name, "_uflow"}, 64'(O_Uflow), 64'(xu));
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_valid"}, 64'(O_Valid), 64'd0);
        chk({name, "_data"},  64'(O_Data),  64'd0);
        chk({name, "_exp"},   64'(O_Exp),   64'd0);
        chk({name, "_shift"}, 64'(O_Shift), 64'd0);
        chk({name, "_zero"},  64'(O_Zero),  64'd0);
        chk({name, "_uflow"}, 64'(O_Uflow), 64'd0);
        chk({name, "_ready"}, 64'(O_Ready), 64'd1);
    endtask

    task automatic drain();
        I_Valid = 1'b0;
        I_Ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clock); #1;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    res_t held;

    initial begin
        // Reset state while reset is asserted and after release.
        #12;
        check_cleared("reset_hold");
        #1 reset = 1'b0;
        @(negedge clock);
        check_cleared("reset_release");

        // Directed vectors.
        directed("lsb_only", 32'h0000_0001, 8'd40, 32'h8000_0000, 8'd9, 5'd31, 1'b0, 1'b0);
        directed("zero_in", 32'h0000_0000, 8'd77, 32'h0, 8'd0, 5'd0, 1'b1, 1'b0);
        directed("msb_set", 32'h8000_0000, 8'd3, 32'h8000_0000, 8'd3, 5'd0, 1'b0, 1'b0);
`ifdef NORM_UFLOW_SAT_EN
        directed("exp_uflow", 32'h0000_1000, 8'd5, 32'h0002_0000, 8'd0, 5'd5, 1'b0, 1'b1);
`else
        directed("exp_wrap", 32'h0000_1000, 8'd5, 32'h8000_0000, 8'd242, 5'd19, 1'b0, 1'b0);
`endif
        drain();

        // Back-to-back operands with a 3-cycle downstream stall after the first result.
        @(posedge clock); #1;
        I_Ready = 1'b1;
        held = model(32'h00F0_0000, 8'd100);
        push_op(32'h00F0_0000, 8'd100);
        push_op(32'h0000_0300, 8'd2);
        I_Ready = 1'b0;
        I_Data  = 32'h1234_5678;
        I_Exp   = 8'd200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_ready", 64'(O_Ready), 64'd0);
            chk("stall_valid", 64'(O_Valid), 64'd1);
            chk("stall_hold", {O_Data, O_Exp, O_Shift, O_Zero, O_Uflow}, 64'(held));
            @(posedge clock); #1;
        end
        I_Ready = 1'b1;
        push_op(32'h1234_5678, 8'd200);
        push_op(32'h0000_0000, 8'd9);
        drain();

        // Full throughput: a result every cycle once the pipeline is filled.
        @(posedge clock); #1;
        for (int i = 0; i < 10; i++) begin
            I_Valid = 1'b1;
            I_Ready = 1'b1;
            I_Data  = $urandom;
            I_Exp   = W'($urandom);
            @(negedge clock);
            if (i >= 2) chk("throughput_valid", 64'(O_Valid), 64'd1);
            @(posedge clock); #1;
        end
        drain();

        // Reset with two operands in flight: nothing may emerge afterwards.
        @(posedge clock); #1;
        push_op(32'h0001_0000, 8'd50);
        push_op(32'h0000_00FF, 8'd60);
        I_Valid = 1'b0;
        reset = 1'b1;
        #1;
        check_cleared("reset_mid");
        sb.delete();
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        // Input accepted on the first edges after release.
        directed("post_reset", 32'h0400_0000, 8'd10, 32'h8000_0000, 8'd5, 5'd5, 1'b0, 1'b0);
        drain();

        // Random stream with random handshakes.
        for (int i = 0; i < 600; i++) begin
            I_Valid = ($urandom_range(0, 9) < 7);
            I_Ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0:       I_Data = 32'd0;
                1:       I_Data = 32'd1 << $urandom_range(0, 31);
                default: I_Data = $urandom >> $urandom_range(0, 31);
            endcase
            I_Exp = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 31)) : W'($urandom);
            @(posedge clock); #1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
